// File: rtl/maxterm_sweep_checker_pkg.sv
// Shared types and sizing helpers for the maxterm sweep checker.
package maxterm_sweep_checker_pkg;

   localparam int unsigned N_VARS_DEF = 3;
   localparam int unsigned SETTLE_DEF = 1;
   localparam int unsigned TBL_W      = 1 << N_VARS_DEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_SAMPLE,
      ST_CHECK
   } state_t;

   // Settle counter width; a zero settle time still needs a one-bit counter.
   function automatic int unsigned cnt_w(input int unsigned settle);
      return (settle == 0) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/maxterm_sweep_checker_if.sv
// Handshake and result bus between the sweep checker and its host/function block.
interface maxterm_sweep_checker_if
   import maxterm_sweep_checker_pkg::*;
   #(parameter int unsigned N_VARS = N_VARS_DEF);

   logic                     start;
   logic [(1<<N_VARS)-1:0]   expected_max;
   logic                     resp;
   logic [N_VARS-1:0]        xyz;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [(1<<N_VARS)-1:0]   table_out;
   logic [N_VARS-1:0]        fail_idx;

   modport master (
      output start, expected_max, resp,
      input  xyz, busy, done, pass, table_out, fail_idx
   );

   modport slave (
      input  start, expected_max, resp,
      output xyz, busy, done, pass, table_out, fail_idx
   );

endinterface

// File: rtl/maxterm_sweep_checker_lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of the mismatch vector, 0 when none.
module maxterm_sweep_checker_lowest_set_idx #(
   parameter int unsigned N_VARS = 3
) (
   input  logic [(1<<N_VARS)-1:0] vec,
   output logic [N_VARS-1:0]      idx_c
);

   // Scan from the top so the lowest set bit wins.
   always_comb begin
      idx_c = '0;
      for (int i = (1 << N_VARS) - 1; i >= 0; i--) begin
         if (vec[i]) idx_c = N_VARS'(i);
      end
   end

endmodule

// File: rtl/maxterm_sweep_checker.sv
// Sequential truth-table sweep of a combinational function against a maxterm mask.
// Optional build macro: MAXTERM_EARLY_ABORT_EN stops the sweep at the first wrong sample.
module maxterm_sweep_checker
   import maxterm_sweep_checker_pkg::*;
#(
   parameter int unsigned N_VARS = N_VARS_DEF,
   parameter int unsigned SETTLE = SETTLE_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   maxterm_sweep_checker_if.slave  bus
);

   localparam int unsigned TW = 1 << N_VARS;
   localparam int unsigned CW = cnt_w(SETTLE);

   state_t             state;
   logic [N_VARS-1:0]  idx;
   logic [CW-1:0]      cnt;
   logic [TW-1:0]      exp_lat;
   logic [TW-1:0]      table_q;
   logic [N_VARS-1:0]  xyz_q;
   logic [N_VARS-1:0]  fail_idx_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [TW-1:0]      mism_c;
   logic [N_VARS-1:0]  low_c;

   // Bits where the sampled function disagrees with the required minterm set.
   assign mism_c = table_q ^ ~exp_lat;

   maxterm_sweep_checker_lowest_set_idx #(.N_VARS(N_VARS)) u_low (
      .vec   (mism_c),
      .idx_c (low_c)
   );

   // Sweep FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         cnt        <= '0;
         exp_lat    <= '0;
         table_q    <= '0;
         xyz_q      <= '0;
         fail_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  exp_lat <= bus.expected_max;
                  table_q <= '0;
                  idx     <= '0;
                  busy_q  <= 1'b1;
                  state   <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               xyz_q <= idx;
               cnt   <= CW'(SETTLE);
               state <= (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
            end
            ST_WAIT: begin
               if (cnt <= CW'(1)) state <= ST_SAMPLE;
               else               cnt   <= cnt - CW'(1);
            end
            ST_SAMPLE: begin
               table_q[idx] <= bus.resp;
`ifdef MAXTERM_EARLY_ABORT_EN
               if (bus.resp != ~exp_lat[idx]) begin
                  state <= ST_CHECK;
               end else
`endif
               if (idx == N_VARS'(TW - 1)) begin
                  state <= ST_CHECK;
               end else begin
                  idx   <= idx + N_VARS'(1);
                  state <= ST_DRIVE;
               end
            end
            ST_CHECK: begin
               pass_q     <= (mism_c == '0);
               fail_idx_q <= low_c;
               busy_q     <= 1'b0;
               done_q     <= 1'b1;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.xyz       = xyz_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.table_out = table_q;
   assign bus.fail_idx  = fail_idx_q;

endmodule

// File: tb/tb_maxterm_sweep_checker.sv
// Randomised and directed bench for maxterm_sweep_checker against a truth-table model.
module tb_maxterm_sweep_checker;

   localparam int unsigned NV       = 3;
   localparam int unsigned TW       = 8;
   localparam int unsigned SETTLE   = 1;
   localparam int          STEP     = SETTLE + 2;
   localparam int          FULL_LAT = TW * STEP + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rtbl;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   maxterm_sweep_checker_if #(.N_VARS(NV)) bus ();

   maxterm_sweep_checker #(.N_VARS(NV), .SETTLE(SETTLE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Function under test: an arbitrary truth table indexed by {x,y,z}.
   always_comb bus.resp = rtbl[bus.xyz];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: what a sweep of table tbl against mask expm must report.
   function automatic void model(input logic [7:0] tbl, input logic [7:0] expm,
                                 output logic [7:0] t, output logic p,
                                 output int fi, output int lat);
      logic [7:0] want;
      bit         found;
      want  = ~expm;
      found = 0;
      fi    = 0;
      for (int i = 0; i < TW; i++) begin
         if (!found && tbl[i] != want[i]) begin
            found = 1;
            fi    = i;
         end
      end
      p   = !found;
      t   = tbl;
      lat = FULL_LAT;
`ifdef MAXTERM_EARLY_ABORT_EN
      if (found) begin
         t   = tbl & 8'((1 << (fi + 1)) - 1);
         lat = (fi + 1) * STEP + 1;
      end
`endif
   endfunction

   // Truth table of a named boolean expression over x (MSB), y, z.
   function automatic logic [7:0] build_tbl(input int which);
      logic [7:0] t;
      logic x, y, z;
      t = '0;
      for (int i = 0; i < TW; i++) begin
         x = 1'((i >> 2) & 1);
         y = 1'((i >> 1) & 1);
         z = 1'(i & 1);
         case (which)
            1:       t[i] = (~y | z) & (~x | ~y);
            2:       t[i] = (y | ~z) & (~y | z);
            default: t[i] = 1'b1;
         endcase
      end
      return t;
   endfunction

   // One full sweep: accept, optional stray start pulse, then check the result.
   task automatic run_sweep(input string tag, input logic [7:0] tbl, input logic [7:0] expm,
                            input int pulse_at, input bit check_xyz);
      logic [7:0] et;
      logic       ep;
      int         efi, elat, done_edge, ndone;
      model(tbl, expm, et, ep, efi, elat);
      @(negedge clk);
      rtbl             = tbl;
      bus.expected_max = expm;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      check({tag, ".busy_acc"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.start        = 1'b0;
      bus.expected_max = 8'($urandom);
      done_edge = -1;
      ndone     = 0;
      for (int k = 1; k <= elat + 4; k++) begin
         if (k == pulse_at) bus.start = 1'b1;
         @(posedge clk); #1;
         if (bus.done) begin
            ndone++;
            if (done_edge < 0) done_edge = k;
         end
         if (check_xyz && k < elat)
            check($sformatf("%s.xyz@%0d", tag, k), 32'(bus.xyz), 32'((k - 1) / STEP));
         @(negedge clk);
         bus.start = 1'b0;
      end
      check({tag, ".done_edge"}, 32'(done_edge), 32'(elat));
      check({tag, ".ndone"},     32'(ndone),     32'd1);
      check({tag, ".busy_end"},  32'(bus.busy),  32'd0);
      check({tag, ".pass"},      32'(bus.pass),  32'(ep));
      check({tag, ".table"},     32'(bus.table_out), 32'(et));
      check({tag, ".fail_idx"},  32'(bus.fail_idx),  32'(efi));
   endtask

   initial begin
      logic [7:0] tbl, expm, et;
      logic       ep;
      int         efi, elat, ndone, first, second;

      reset            = 1'b1;
      bus.start        = 1'b0;
      bus.expected_max = '0;
      rtbl             = '0;
      #12;
      check("rst.xyz",   32'(bus.xyz),       32'd0);
      check("rst.busy",  32'(bus.busy),      32'd0);
      check("rst.done",  32'(bus.done),      32'd0);
      check("rst.pass",  32'(bus.pass),      32'd0);
      check("rst.table", 32'(bus.table_out), 32'd0);
      check("rst.fidx",  32'(bus.fail_idx),  32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed sweeps from the function catalogue.
      run_sweep("t1", build_tbl(1), 8'hC4, 0, 1'b1);
      check("t1.table_const", 32'(bus.table_out), 32'h3B);
      check("t1.pass_const",  32'(bus.pass),      32'd1);
      run_sweep("t2", build_tbl(2), 8'h66, 0, 1'b1);
      check("t2.table_const", 32'(bus.table_out), 32'h99);
      run_sweep("t3", build_tbl(0), 8'hC4, 0, 1'b0);
      check("t3.fidx_const", 32'(bus.fail_idx), 32'd2);
      run_sweep("t6", build_tbl(1), 8'hC4, 5, 1'b0);

      // Reset mid-sweep after a passing result so cleared outputs are visible.
      @(negedge clk);
      rtbl             = build_tbl(2);
      bus.expected_max = 8'h66;
      bus.start        = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("t5.xyz",   32'(bus.xyz),       32'd0);
      check("t5.busy",  32'(bus.busy),      32'd0);
      check("t5.pass",  32'(bus.pass),      32'd0);
      check("t5.table", 32'(bus.table_out), 32'd0);
      check("t5.fidx",  32'(bus.fail_idx),  32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.done) ndone++;
      end
      check("t5.no_done", 32'(ndone), 32'd0);
      run_sweep("t5.after", build_tbl(2), 8'h66, 0, 1'b1);

      // Start held high re-triggers back-to-back sweeps.
      tbl  = 8'($urandom);
      expm = ~tbl;
      model(tbl, expm, et, ep, efi, elat);
      @(negedge clk);
      rtbl             = tbl;
      bus.expected_max = expm;
      bus.start        = 1'b1;
      @(posedge clk);
      first  = -1;
      second = -1;
      ndone  = 0;
      for (int k = 1; k <= 2 * elat + 2; k++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            ndone++;
            if (first < 0) first = k;
            else if (second < 0) second = k;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (elat + 2) @(posedge clk);
      check("hold.first",  32'(first),  32'(elat));
      check("hold.second", 32'(second), 32'(2 * elat + 1));
      check("hold.ndone",  32'(ndone),  32'd2);

      // Random tables, half of them matching their mask.
      for (int n = 0; n < 16; n++) begin
         tbl = 8'($urandom);
         if ($urandom_range(1, 0) == 1) expm = ~tbl;
         else                           expm = 8'($urandom);
         run_sweep($sformatf("rnd%0d", n), tbl, expm,
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 2)) : 0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
